decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage.sv | 129 ++++++++++++
 tb/tb_decode_stage.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// Decode stage: IF/ID pipeline register, 32x32 register file with same-cycle
// write-through, immediate extension and load-use hazard detection.
module decode_stage #(
    parameter logic [31:0] NOP_INSTR  = 32'h3400_0000,
    parameter logic [24:0] NOP_BUNDLE = 25'b0_0000_0110_0010_0000_0011_0001
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_in,
    input  logic [24:0] bundle_in,
    input  logic [31:0] pc_seq_in,
    input  logic        stall_in,
    input  logic        flush_in,
    input  logic        wb_we_in,
    input  logic [4:0]  wb_addr_in,
    input  logic [31:0] wb_data_in,
    input  logic        ex_mem_re_in,
    input  logic [4:0]  ex_rt_in,
    output logic [31:0] rs_data_out,
    output logic [31:0] rt_data_out,
    output logic [31:0] imm_ext_out,
    output logic [4:0]  rs_out,
    output logic [4:0]  rt_out,
    output logic [4:0]  rd_out,
    output logic [4:0]  shamt_out,
    output logic [31:0] instr_out,
    output logic [24:0] bundle_out,
    output logic [31:0] pc_seq_out,
    output logic        valid_out,
    output logic        hazard_stall_out
);

    logic [31:0] r_instr;
    logic [24:0] r_bundle;
    logic [31:0] r_pc_seq;
    logic        r_valid;
    logic [31:0] r_regs [32];

    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic        w_hazard;

    assign w_rs = r_instr[25:21];
    assign w_rt = r_instr[20:16];

    // Load-use hazard: the load in EX targets a source of the latched instruction.
    assign w_hazard = r_valid && ex_mem_re_in && (ex_rt_in != 5'd0) &&
                      ((ex_rt_in == w_rs) || (ex_rt_in == w_rt));

    // IF/ID register: flush beats stall/hazard, which beat capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_instr  <= NOP_INSTR;
            r_bundle <= NOP_BUNDLE;
            r_pc_seq <= '0;
            r_valid  <= 1'b0;
        end else if (flush_in) begin
            // pc_seq deliberately kept so the bubble still carries a sensible PC
            r_instr  <= NOP_INSTR;
            r_bundle <= NOP_BUNDLE;
            r_valid  <= 1'b0;
        end else if (!(stall_in || w_hazard)) begin
            r_instr  <= instr_in;
            r_bundle <= bundle_in;
            r_pc_seq <= pc_seq_in;
            r_valid  <= 1'b1;
        end
    end

    // Register file write port; register 0 is never written.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else if (wb_we_in && (wb_addr_in != 5'd0)) begin
            r_regs[wb_addr_in] <= wb_data_in;
        end
    end

    // Operand reads with same-cycle writeback bypass; register 0 reads as zero.
    always_comb begin
        rs_data_out = '0;
        rt_data_out = '0;
        if (w_rs != 5'd0) begin
            if (wb_we_in && (wb_addr_in == w_rs)) begin
                rs_data_out = wb_data_in;
            end else begin
                rs_data_out = r_regs[w_rs];
            end
        end
        if (w_rt != 5'd0) begin
            if (wb_we_in && (wb_addr_in == w_rt)) begin
                rt_data_out = wb_data_in;
            end else begin
                rt_data_out = r_regs[w_rt];
            end
        end
    end

    // Immediate extension: bundle bit 19 selects zero-extension.
    always_comb begin
        if (r_bundle[19]) begin
            imm_ext_out = {16'h0000, r_instr[15:0]};
        end else begin
            imm_ext_out = {{16{r_instr[15]}}, r_instr[15:0]};
        end
    end

    // Outputs to execute; a hazard injects a bubble while the latch holds.
    always_comb begin
        rs_out           = w_rs;
        rt_out           = w_rt;
        rd_out           = r_instr[15:11];
        shamt_out        = r_instr[10:6];
        pc_seq_out       = r_pc_seq;
        hazard_stall_out = w_hazard;
        if (w_hazard) begin
            instr_out  = NOP_INSTR;
            bundle_out = NOP_BUNDLE;
            valid_out  = 1'b0;
        end else begin
            instr_out  = r_instr;
            bundle_out = r_bundle;
            valid_out  = r_valid;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: a spec-level model checked every negative clock edge,
// plus directed vectors with hand-computed literal expectations.
module tb_decode_stage;

    localparam logic [31:0] NOPI = 32'h3400_0000;
    localparam logic [24:0] NOPB = 25'b0_0000_0110_0010_0000_0011_0001;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr_in;
    logic [24:0] bundle_in;
    logic [31:0] pc_seq_in;
    logic        stall_in;
    logic        flush_in;
    logic        wb_we_in;
    logic [4:0]  wb_addr_in;
    logic [31:0] wb_data_in;
    logic        ex_mem_re_in;
    logic [4:0]  ex_rt_in;
    logic [31:0] rs_data_out;
    logic [31:0] rt_data_out;
    logic [31:0] imm_ext_out;
    logic [4:0]  rs_out;
    logic [4:0]  rt_out;
    logic [4:0]  rd_out;
    logic [4:0]  shamt_out;
    logic [31:0] instr_out;
    logic [24:0] bundle_out;
    logic [31:0] pc_seq_out;
    logic        valid_out;
    logic        hazard_stall_out;

    int n_vec = 0;
    int n_err = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk              (clk),
        .reset            (reset),
        .instr_in         (instr_in),
        .bundle_in        (bundle_in),
        .pc_seq_in        (pc_seq_in),
        .stall_in         (stall_in),
        .flush_in         (flush_in),
        .wb_we_in         (wb_we_in),
        .wb_addr_in       (wb_addr_in),
        .wb_data_in       (wb_data_in),
        .ex_mem_re_in     (ex_mem_re_in),
        .ex_rt_in         (ex_rt_in),
        .rs_data_out      (rs_data_out),
        .rt_data_out      (rt_data_out),
        .imm_ext_out      (imm_ext_out),
        .rs_out           (rs_out),
        .rt_out           (rt_out),
        .rd_out           (rd_out),
        .shamt_out        (shamt_out),
        .instr_out        (instr_out),
        .bundle_out       (bundle_out),
        .pc_seq_out       (pc_seq_out),
        .valid_out        (valid_out),
        .hazard_stall_out (hazard_stall_out)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_instr;
    logic [24:0] m_bundle;
    logic [31:0] m_pc;
    logic        m_valid;
    logic [31:0] m_regs [32];

    function automatic logic m_haz();
        logic [4:0] s;
        logic [4:0] t;
        s = m_instr[25:21];
        t = m_instr[20:16];
        return m_valid && ex_mem_re_in && ex_rt_in != 0 && (ex_rt_in == s || ex_rt_in == t);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (wb_we_in && wb_addr_in == a) return wb_data_in;
        return m_regs[a];
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_instr  <= NOPI;
            m_bundle <= NOPB;
            m_pc     <= 32'h0;
            m_valid  <= 1'b0;
            for (int i = 0; i < 32; i++) m_regs[i] <= 32'h0;
        end else begin
            if (wb_we_in && wb_addr_in != 0) m_regs[wb_addr_in] <= wb_data_in;
            if (flush_in) begin
                m_instr  <= NOPI;
                m_bundle <= NOPB;
                m_valid  <= 1'b0;
            end else if (!(stall_in || m_haz())) begin
                m_instr  <= instr_in;
                m_bundle <= bundle_in;
                m_pc     <= pc_seq_in;
                m_valid  <= 1'b1;
            end
        end
    end

    // Compare process: every negative edge once the bench is running.
    always @(negedge clk) begin
        if (chk_en) begin
            logic        h;
            logic [31:0] imm;
            h = m_haz();
            imm = m_bundle[19] ? {16'h0, m_instr[15:0]} : {{16{m_instr[15]}}, m_instr[15:0]};
            check("m_hazard", 32'(hazard_stall_out), 32'(h));
            check("m_instr", instr_out, h ? NOPI : m_instr);
            check("m_bundle", 32'(bundle_out), 32'(h ? NOPB : m_bundle));
            check("m_valid", 32'(valid_out), 32'(h ? 1'b0 : m_valid));
            check("m_pc", pc_seq_out, m_pc);
            check("m_rs_data", rs_data_out, m_read(m_instr[25:21]));
            check("m_rt_data", rt_data_out, m_read(m_instr[20:16]));
            check("m_imm", imm_ext_out, imm);
            check("m_fields", {12'h0, rs_out, rt_out, rd_out, shamt_out},
                  {12'h0, m_instr[25:6]});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed vectors ----------------
    initial begin
        reset = 1'b0;
        instr_in = '0; bundle_in = '0; pc_seq_in = '0;
        stall_in = 1'b0; flush_in = 1'b0;
        wb_we_in = 1'b0; wb_addr_in = '0; wb_data_in = '0;
        ex_mem_re_in = 1'b0; ex_rt_in = '0;
        repeat (2) @(posedge clk);
        #1;
        // Capture addi $8,$9,-1 while writing reg9=5
        reset = 1'b1;
        wb_we_in = 1'b1; wb_addr_in = 5'd9; wb_data_in = 32'd5;
        instr_in = 32'h2128_FFFF; bundle_in = 25'h0; pc_seq_in = 32'h104;
        #1;
        check("rst_valid", 32'(valid_out), 32'h0);
        check("rst_hazard", 32'(hazard_stall_out), 32'h0);
        check("rst_rs_data", rs_data_out, 32'h0);
        check("rst_rt_data", rt_data_out, 32'h0);
        check("rst_instr", instr_out, NOPI);
        chk_en = 1'b1;

        cyc();
        wb_we_in = 1'b0; stall_in = 1'b1;
        #1;
        check("cap_rs", 32'(rs_out), 32'd9);
        check("cap_rt", 32'(rt_out), 32'd8);
        check("cap_rs_data", rs_data_out, 32'd5);
        check("cap_imm", imm_ext_out, 32'hFFFF_FFFF);
        check("cap_valid", 32'(valid_out), 32'h1);
        check("cap_pc", pc_seq_out, 32'h104);

        // Write-through while held
        wb_we_in = 1'b1; wb_addr_in = 5'd9; wb_data_in = 32'hDEAD_BEEF;
        #1;
        check("wt_rs_data", rs_data_out, 32'hDEAD_BEEF);

        cyc();
        stall_in = 1'b0; wb_addr_in = 5'd0; wb_data_in = 32'h1234_5678;
        instr_in = 32'h0009_4020;
        #1;
        check("wt_reg9", rs_data_out, 32'hDEAD_BEEF);

        cyc();
        ex_mem_re_in = 1'b1; ex_rt_in = 5'd0;
        #1;
        check("r0_rs_data", rs_data_out, 32'h0);
        check("r0_rt_data", rt_data_out, 32'hDEAD_BEEF);
        check("r0_rd", 32'(rd_out), 32'd8);
        check("r0_nohaz", 32'(hazard_stall_out), 32'h0);

        // Zero- versus sign-extension
        wb_we_in = 1'b0; ex_mem_re_in = 1'b0;
        instr_in = 32'h3508_8000; bundle_in = 25'h008_0000;
        cyc();
        instr_in = 32'h2108_8000; bundle_in = 25'h0;
        #1;
        check("imm_zext", imm_ext_out, 32'h0000_8000);
        cyc();
        #1;
        check("imm_sext", imm_ext_out, 32'hFFFF_8000);

        // Load-use hazard on rs=3
        instr_in = 32'h0064_1020; bundle_in = 25'h001_2345; pc_seq_in = 32'h200;
        cyc();
        instr_in = 32'hAAAA_AAAA; pc_seq_in = 32'h300;
        ex_mem_re_in = 1'b1; ex_rt_in = 5'd3;
        #1;
        check("lu_hazard", 32'(hazard_stall_out), 32'h1);
        check("lu_bundle", 32'(bundle_out), 32'(NOPB));
        check("lu_instr", instr_out, NOPI);
        check("lu_valid", 32'(valid_out), 32'h0);
        check("lu_rs", 32'(rs_out), 32'd3);
        cyc();
        ex_mem_re_in = 1'b0;
        #1;
        check("lu_held_instr", instr_out, 32'h0064_1020);
        check("lu_held_valid", 32'(valid_out), 32'h1);
        check("lu_held_bundle", 32'(bundle_out), 32'h0001_2345);
        check("lu_held_pc", pc_seq_out, 32'h200);

        // Flush beats stall
        cyc();
        flush_in = 1'b1; stall_in = 1'b1;
        cyc();
        flush_in = 1'b0; stall_in = 1'b0;
        instr_in = 32'h0064_1020; pc_seq_in = 32'h400;
        #1;
        check("fl_instr", instr_out, 32'h3400_0000);
        check("fl_valid", 32'(valid_out), 32'h0);
        check("fl_pc", pc_seq_out, 32'h300);

        // Flush beats a same-cycle hazard
        cyc();
        flush_in = 1'b1; ex_mem_re_in = 1'b1; ex_rt_in = 5'd3;
        #1;
        check("flh_hazard_now", 32'(hazard_stall_out), 32'h1);
        cyc();
        flush_in = 1'b0;
        #1;
        check("flh_valid", 32'(valid_out), 32'h0);
        check("flh_hazard", 32'(hazard_stall_out), 32'h0);
        check("flh_pc", pc_seq_out, 32'h400);

        // Async reset in the middle of a stall
        cyc();
        stall_in = 1'b1;
        #1;
        check("ar_pre_hazard", 32'(hazard_stall_out), 32'h1);
        #1;
        reset = 1'b0;
        #1;
        check("ar_valid", 32'(valid_out), 32'h0);
        check("ar_hazard", 32'(hazard_stall_out), 32'h0);
        check("ar_instr", instr_out, NOPI);
        check("ar_bundle", 32'(bundle_out), 32'(NOPB));
        check("ar_pc", pc_seq_out, 32'h0);
        check("ar_rs_data", rs_data_out, 32'h0);
        reset = 1'b1;
        stall_in = 1'b0; ex_mem_re_in = 1'b0;
        instr_in = 32'h0128_4020;
        cyc();
        #1;
        check("ar_cap_valid", 32'(valid_out), 32'h1);
        check("ar_cap_rs", 32'(rs_out), 32'd9);
        check("ar_reg9", rs_data_out, 32'h0);
        check("ar_reg8", rt_data_out, 32'h0);

        cyc();
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
